// File: rtl/fma16_dot_seq_if.sv
// Operand/command/result bundle between a dot-product client and fma16_dot_seq.
// The master drives the command and operand stream; the slave answers with ready/busy/done/results.
`ifndef FLEN
`define FLEN 16
`endif

interface fma16_dot_seq_if #(
   parameter int LEN_W = 8,
   parameter int FLEN  = `FLEN
) ();
   logic             start;
   logic [LEN_W-1:0] len;
   logic [FLEN-1:0]  acc_init;
   logic [1:0]       roundmode;
   logic             in_valid;
   logic             in_ready;
   logic [FLEN-1:0]  in_x;
   logic [FLEN-1:0]  in_y;
   logic             busy;
   logic             done;
   logic [FLEN-1:0]  out_result;
   logic [3:0]       out_flags;

   modport master (
      output start, len, acc_init, roundmode, in_valid, in_x, in_y,
      input  in_ready, busy, done, out_result, out_flags
   );

   modport slave (
      input  start, len, acc_init, roundmode, in_valid, in_x, in_y,
      output in_ready, busy, done, out_result, out_flags
   );
endinterface

// File: rtl/fma16_dot_seq.sv
// Dot-product sequencer around a combinational fma16: acc = acc_init + sum(x_i*y_i).
// Optional macro FMA16_DOT_PIPE_EN registers the fma16 result and inserts a WAIT state per element.
`ifndef FLEN
`define FLEN 16
`endif

module fma16_dot_seq #(
   parameter int LEN_W = 8,
   parameter int FLEN  = `FLEN
) (
   input  logic            i_clk,
   input  logic            i_reset,
   fma16_dot_seq_if.slave  s_bus,
   output logic [FLEN-1:0] o_fma_x,
   output logic [FLEN-1:0] o_fma_y,
   output logic [FLEN-1:0] o_fma_z,
   output logic            o_fma_mul,
   output logic            o_fma_add,
   output logic            o_fma_negp,
   output logic            o_fma_negz,
   output logic [1:0]      o_fma_roundmode,
   input  logic [FLEN-1:0] i_fma_result,
   input  logic [3:0]      i_fma_flags
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [LEN_W-1:0] CNT_ZERO = LEN_W'(0);
   localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);

   state_t           r_state;
   logic [FLEN-1:0]  r_acc;
   logic [LEN_W-1:0] r_cnt;
   logic [1:0]       r_rm;
   logic [3:0]       r_flags;
   logic             r_in_ready;
   logic             r_busy;
   logic             r_done;
   logic [FLEN-1:0]  r_out_result;
   logic [3:0]       r_out_flags;
`ifdef FMA16_DOT_PIPE_EN
   logic [FLEN-1:0]  r_res;
   logic [3:0]       r_flg;
`endif

   logic             w_hs;

   // in_ready is registered and high only in RUN, so it doubles as the state qualifier
   assign w_hs = s_bus.in_valid & r_in_ready;

   assign o_fma_x         = s_bus.in_x;
   assign o_fma_y         = s_bus.in_y;
   assign o_fma_z         = r_acc;
   assign o_fma_mul       = 1'b1;
   assign o_fma_add       = 1'b1;
   assign o_fma_negp      = 1'b0;
   assign o_fma_negz      = 1'b0;
   assign o_fma_roundmode = r_rm;

   assign s_bus.in_ready   = r_in_ready;
   assign s_bus.busy       = r_busy;
   assign s_bus.done       = r_done;
   assign s_bus.out_result = r_out_result;
   assign s_bus.out_flags  = r_out_flags;

   // Sequencer state machine with registered handshake/status outputs
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_acc        <= {FLEN{1'b0}};
         r_cnt        <= CNT_ZERO;
         r_rm         <= 2'b00;
         r_flags      <= 4'b0000;
         r_in_ready   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_out_result <= {FLEN{1'b0}};
         r_out_flags  <= 4'b0000;
`ifdef FMA16_DOT_PIPE_EN
         r_res        <= {FLEN{1'b0}};
         r_flg        <= 4'b0000;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (s_bus.start) begin
                  r_acc   <= s_bus.acc_init;
                  r_cnt   <= s_bus.len;
                  r_rm    <= s_bus.roundmode;
                  r_flags <= 4'b0000;
                  r_busy  <= 1'b1;
                  if (s_bus.len == CNT_ZERO) begin
                     r_state    <= S_DONE;
                     r_done     <= 1'b1;
                     r_in_ready <= 1'b0;
                  end else begin
                     r_state    <= S_RUN;
                     r_in_ready <= 1'b1;
                  end
               end else begin
                  r_busy     <= 1'b0;
                  r_in_ready <= 1'b0;
               end
            end

            S_RUN: begin
               if (w_hs) begin
                  r_cnt <= r_cnt - CNT_ONE;
`ifdef FMA16_DOT_PIPE_EN
                  r_res      <= i_fma_result;
                  r_flg      <= i_fma_flags;
                  r_state    <= S_WAIT;
                  r_in_ready <= 1'b0;
`else
                  r_acc   <= i_fma_result;
                  r_flags <= r_flags | i_fma_flags;
                  if (r_cnt == CNT_ONE) begin
                     r_state    <= S_DONE;
                     r_in_ready <= 1'b0;
                     r_done     <= 1'b1;
                  end else begin
                     r_state <= S_RUN;
                  end
`endif
               end else begin
                  r_state <= S_RUN;
               end
            end

`ifdef FMA16_DOT_PIPE_EN
            // cnt was already decremented on the handshake, so zero marks the last element
            S_WAIT: begin
               r_acc   <= r_res;
               r_flags <= r_flags | r_flg;
               if (r_cnt == CNT_ZERO) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state    <= S_RUN;
                  r_in_ready <= 1'b1;
               end
            end
`endif

            S_DONE: begin
               r_out_result <= r_acc;
               r_out_flags  <= r_flags;
               r_done       <= 1'b0;
               r_busy       <= 1'b0;
               r_in_ready   <= 1'b0;
               r_state      <= S_IDLE;
            end

            default: begin
               r_state    <= S_IDLE;
               r_done     <= 1'b0;
               r_busy     <= 1'b0;
               r_in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fma16_dot_seq.sv
// Directed bench for fma16_dot_seq with a table-driven fma16 stand-in and a done-triggered scoreboard.
`timescale 1ns/1ps

module tb_fma16_dot_seq;
   localparam int LEN_W = 8;
   localparam int FLEN  = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fma16_dot_seq_if #(.LEN_W(LEN_W), .FLEN(FLEN)) bus ();

   logic [15:0] fma_x, fma_y, fma_z, fma_result;
   logic        fma_mul, fma_add, fma_negp, fma_negz;
   logic [1:0]  fma_rm;
   logic [3:0]  fma_flags;

   fma16_dot_seq #(.LEN_W(LEN_W), .FLEN(FLEN)) dut (
      .i_clk           (clk),
      .i_reset         (reset),
      .s_bus           (bus),
      .o_fma_x         (fma_x),
      .o_fma_y         (fma_y),
      .o_fma_z         (fma_z),
      .o_fma_mul       (fma_mul),
      .o_fma_add       (fma_add),
      .o_fma_negp      (fma_negp),
      .o_fma_negz      (fma_negz),
      .o_fma_roundmode (fma_rm),
      .i_fma_result    (fma_result),
      .i_fma_flags     (fma_flags)
   );

   // Hand-computed half-precision x*y+z for every step used below; anything else gives a NaN marker.
   function automatic logic [19:0] fma_model(input logic [15:0] x, input logic [15:0] y,
                                             input logic [15:0] z, input logic ctrl_ok);
      logic [19:0] r;
      r = {16'h7E00, 4'b1000};
      if (ctrl_ok) begin
         case ({x, y, z})
            {16'h3C00, 16'h4000, 16'h0000}: r = {16'h4000, 4'b0000}; // 1*2+0 = 2
            {16'h4000, 16'h4200, 16'h4000}: r = {16'h4800, 4'b0000}; // 2*3+2 = 8
            {16'h3C00, 16'h3C00, 16'h3800}: r = {16'h3E00, 4'b0000}; // 1+0.5 = 1.5
            {16'h3C00, 16'h3C00, 16'h3E00}: r = {16'h4100, 4'b0000}; // 1+1.5 = 2.5
            {16'h3C00, 16'h3C00, 16'h4100}: r = {16'h4300, 4'b0000}; // 1+2.5 = 3.5
            {16'h7BFF, 16'h7BFF, 16'h0000}: r = {16'h7C00, 4'b0101}; // overflow+inexact
            {16'h3C00, 16'h3C00, 16'h7C00}: r = {16'h7C00, 4'b0000}; // inf stays inf
            {16'h3C00, 16'h3C00, 16'h0000}: r = {16'h3C00, 4'b0000}; // 1
            {16'h3C00, 16'h3C00, 16'h3C00}: r = {16'h4000, 4'b0000}; // 2
            default:                        r = {16'h7E00, 4'b1000};
         endcase
      end
      return r;
   endfunction

   always_comb begin
      {fma_result, fma_flags} = fma_model(fma_x, fma_y, fma_z,
         fma_mul & fma_add & ~fma_negp & ~fma_negz & (fma_rm == 2'b00));
   end

   typedef struct packed {
      logic [15:0] res;
      logic [3:0]  flg;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
   endtask

   // Scoreboard monitor: results are registered on DONE exit, so sample one cycle after done
   initial begin
      forever begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("out_result", {16'h0, bus.out_result}, {16'h0, e.res});
               check("out_flags", {28'h0, bus.out_flags}, {28'h0, e.flg});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic do_start(input logic [7:0] l, input logic [15:0] a);
      bus.start     = 1'b1;
      bus.len       = l;
      bus.acc_init  = a;
      bus.roundmode = 2'b00;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic send(input logic [15:0] x, input logic [15:0] y);
      bit hs;
      hs = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_x     = x;
      bus.in_y     = y;
      for (int i = 0; i < 20 && !hs; i++) begin
         @(negedge clk);
         hs = (bus.in_ready === 1'b1);
         @(posedge clk); #1;
      end
      if (!hs) check("handshake_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_done(input int bound);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(negedge clk);
         seen = (bus.done === 1'b1);
      end
      check("done_seen", {31'h0, seen}, 32'd1);
   endtask

   initial begin
      reset = 1'b1;
      bus.start = 1'b0; bus.len = 8'd0; bus.acc_init = 16'h0; bus.roundmode = 2'b00;
      bus.in_valid = 1'b0; bus.in_x = 16'h0; bus.in_y = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'h0, bus.busy}, 32'd0);
      check("rst_in_ready", {31'h0, bus.in_ready}, 32'd0);
      check("rst_done", {31'h0, bus.done}, 32'd0);
      check("rst_out_result", {16'h0, bus.out_result}, 32'h0);
      check("rst_out_flags", {28'h0, bus.out_flags}, 32'h0);
      reset = 1'b0;
      idle(2);

      // 1*2 + 2*3 = 8, back to back
      exp_q.push_back('{16'h4800, 4'b0000});
      do_start(8'd2, 16'h0000);
      check("s1_in_ready_run", {31'h0, bus.in_ready}, 32'd1);
      check("s1_busy_run", {31'h0, bus.busy}, 32'd1);
      send(16'h3C00, 16'h4000);
`ifdef FMA16_DOT_PIPE_EN
      check("s1_in_ready_after_hs1", {31'h0, bus.in_ready}, 32'd0);
`else
      check("s1_in_ready_after_hs1", {31'h0, bus.in_ready}, 32'd1);
`endif
      send(16'h4000, 16'h4200);
      idle(0);
`ifdef FMA16_DOT_PIPE_EN
      @(negedge clk);
      check("s1_done_wait", {31'h0, bus.done}, 32'd0);
`endif
      @(negedge clk);
      check("s1_done_cycle", {31'h0, bus.done}, 32'd1);
      check("s1_in_ready_done", {31'h0, bus.in_ready}, 32'd0);
      @(posedge clk); #1;
      idle(3);

      // len == 0: straight to DONE, acc_init passes through
      exp_q.push_back('{16'h4200, 4'b0000});
      do_start(8'd0, 16'h4200);
      check("s2_done_next", {31'h0, bus.done}, 32'd1);
      check("s2_no_in_ready", {31'h0, bus.in_ready}, 32'd0);
      check("s2_busy", {31'h0, bus.busy}, 32'd1);
      idle(3);

      // gaps in in_valid, plus a start while busy that must be ignored
      exp_q.push_back('{16'h4300, 4'b0000});
      do_start(8'd3, 16'h3800);
      send(16'h3C00, 16'h3C00);
      bus.in_valid = 1'b0;
      bus.start = 1'b1; bus.len = 8'd0; bus.acc_init = 16'h1234;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      send(16'h3C00, 16'h3C00);
      check("s3_no_early_done", {31'h0, bus.done}, 32'd0);
      idle(1);
      send(16'h3C00, 16'h3C00);
`ifdef FMA16_DOT_PIPE_EN
      check("s3_done_after_hs3", {31'h0, bus.done}, 32'd0);
`else
      check("s3_done_after_hs3", {31'h0, bus.done}, 32'd1);
`endif
      idle(0);
      wait_done(10);
      idle(3);

      // overflow in step 1 must survive a clean step 2
      exp_q.push_back('{16'h7C00, 4'b0101});
      do_start(8'd2, 16'h0000);
      send(16'h7BFF, 16'h7BFF);
      send(16'h3C00, 16'h3C00);
      idle(0);
      wait_done(10);
      idle(3);

      // reset mid-operation, then a fresh single-element run
      do_start(8'd4, 16'h0000);
      send(16'h3C00, 16'h3C00);
      send(16'h3C00, 16'h3C00);
      bus.in_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("s5_busy_after_rst", {31'h0, bus.busy}, 32'd0);
      check("s5_in_ready_after_rst", {31'h0, bus.in_ready}, 32'd0);
      check("s5_done_after_rst", {31'h0, bus.done}, 32'd0);
      check("s5_out_result_after_rst", {16'h0, bus.out_result}, 32'h0);
      idle(4);
      exp_q.push_back('{16'h3C00, 4'b0000});
      do_start(8'd1, 16'h0000);
      send(16'h3C00, 16'h3C00);
      idle(0);
      wait_done(10);
      idle(4);

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
